// File: rtl/neuron_result_reader_pkg.sv
// Shared definitions for the neuron result reader: frame FSM states,
// activation encodings and default datapath widths.
package neuron_result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } frame_state_t;

  localparam int unsigned ACT_PASS = 0;
  localparam int unsigned ACT_RELU = 1;

  localparam int unsigned N_DEFAULT = 16;
  localparam int unsigned Q_DEFAULT = 8;

endpackage

// File: rtl/neuron_result_reader_result_fifo.sv
// Result buffer: circular storage of value plus end-of-frame tag, with
// registered count/full/empty that all reflect the state after the last edge.
module result_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  input  logic                     push_last,
  input  logic                     tag_last,
  output logic [W-1:0]             head_data,
  output logic                     head_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]  data_mem [DEPTH];
  logic          last_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] tail_prev;
  logic [AW:0]   count_next;

  always_comb begin
    tail_prev  = tail - PTR_ONE;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) begin
        data_mem[tail] <= push_data;
        last_mem[tail] <= push_last;
        tail           <= tail + PTR_ONE;
      end
      if (tag_last) begin
        last_mem[tail_prev] <= 1'b1;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == CNT_MAX);
      empty <= (count_next == '0);
    end
  end

  assign head_data = data_mem[head];
  assign head_last = last_mem[head];

endmodule

// File: rtl/neuron_result_reader.sv
// Captures neuron results (optionally ReLU-clamped) into a buffer, tracks
// frame boundaries and presents entries to the host over a valid/ready port.
module neuron_result_reader
  import neuron_result_reader_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned Q     = Q_DEFAULT,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ACT   = ACT_RELU
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_write,
  input  logic [N-1:0]           data_out,
  input  logic                   done,
  input  logic                   rd_ready,
  input  logic                   clear_ovf,
  output logic                   rd_valid,
  output logic [N-1:0]           rd_data,
  output logic                   rd_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   frame_ready
);

  if (Q >= N) begin : g_q_check
    $error("Q must be in the range 0..N-1");
  end

  frame_state_t state;
  logic [N-1:0] stored;
  logic [N-1:0] head_data;
  logic         head_last;
  logic         pop;
  logic         accept;
  logic         drop;
  logic         tagged_write;
  logic         retro_tag;

  always_comb begin
    stored = data_out;
    if (ACT == ACT_RELU && data_out[N-1]) begin
      stored = '0;
    end
  end

  assign pop          = rd_ready && !empty;
  assign accept       = res_write && (!full || pop);
  assign drop         = res_write && full && !pop;
  assign tagged_write = accept && done;
  // A lone done closes the frame on the newest buffered entry.
  assign retro_tag    = done && !res_write && !empty;

  result_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (pop),
    .push_data (stored),
    .push_last (done),
    .tag_last  (retro_tag),
    .head_data (head_data),
    .head_last (head_last),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : head_data;
  assign rd_last  = !empty && head_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      overflow    <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end

      if (drop && done) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              state <= COLLECT;
            end
          end
          COLLECT: begin
            if (tagged_write || retro_tag) begin
              state       <= FLUSH;
              frame_ready <= 1'b1;
            end
          end
          FLUSH: begin
            if (pop && head_last) begin
              state <= (accept && !done) ? COLLECT : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
